// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, address decode to GPIO/UART,
// SETUP/ACCESS sequencing with a per-transfer timeout. All outputs are registered.
module apb_master_arb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state, next;
  logic              gnt_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        tgt_q;
  logic [7:0]        cnt_q;

  logic              pick, take, owner, bus_on;
  logic [ADDR_W-1:0] pick_addr, addr_n;
  logic              pick_wr, wr_n;
  logic [DATA_W-1:0] pick_wdata, wdata_n;
  logic [1:0]        pick_tgt, tgt_n;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  // On a tie the requester not served last wins; otherwise whichever is asking.
  assign pick       = (req0 && req1) ? ~last_q : req1;
  assign pick_addr  = pick ? addr1  : addr0;
  assign pick_wr    = pick ? wr1    : wr0;
  assign pick_wdata = pick ? wdata1 : wdata0;

  always_comb begin
    case (pick_addr[15:12])
      4'h1:    pick_tgt = 2'b01;
      4'h2:    pick_tgt = 2'b10;
      default: pick_tgt = 2'b00;
    endcase
  end

  always_comb begin
    next     = state;
    take     = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take = 1'b1;
          // An unmapped address completes immediately with an error, no bus cycle.
          if (pick_tgt != 2'b00) begin
            next = SETUP;
          end else begin
            next    = RESP;
            rsp_err = 1'b1;
          end
        end
      end
      SETUP: next = ACCESS;
      ACCESS: begin
        if (pready) begin
          next     = RESP;
          rsp_err  = pslverr;
          rsp_data = (!wr_q && !pslverr) ? prdata : '0;
        end else if (cnt_q == TO_LAST) begin
          next    = RESP;
          rsp_err = 1'b1;
        end
      end
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // Values the registered outputs take on the next edge: fresh grant or latched request.
  assign owner   = take ? pick       : gnt_q;
  assign tgt_n   = take ? pick_tgt   : tgt_q;
  assign addr_n  = take ? pick_addr  : addr_q;
  assign wr_n    = take ? pick_wr    : wr_q;
  assign wdata_n = take ? pick_wdata : wdata_q;
  assign bus_on  = (next == SETUP) || (next == ACCESS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      tgt_q   <= 2'b00;
      cnt_q   <= '0;
      psel    <= 2'b00;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (take) begin
        gnt_q   <= pick;
        addr_q  <= pick_addr;
        wr_q    <= pick_wr;
        wdata_q <= pick_wdata;
        tgt_q   <= pick_tgt;
      end
      cnt_q <= (state == ACCESS && next == ACCESS) ? cnt_q + 8'd1 : 8'd0;
      if (state == RESP) last_q <= gnt_q;

      psel    <= bus_on ? tgt_n : 2'b00;
      penable <= (next == ACCESS);
      pwrite  <= bus_on && wr_n;
      paddr   <= bus_on ? addr_n  : '0;
      pwdata  <= bus_on ? wdata_n : '0;

      done0  <= (next == RESP) && !owner;
      done1  <= (next == RESP) &&  owner;
      err0   <= (next == RESP) && !owner && rsp_err;
      err1   <= (next == RESP) &&  owner && rsp_err;
      rdata0 <= ((next == RESP) && !owner) ? rsp_data : '0;
      rdata1 <= ((next == RESP) &&  owner) ? rsp_data : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Randomized bench for apb_master_arb: transaction-level latency/arbitration model
// plus a reactive APB slave whose wait states and responses are planned per transfer.
module tb_apb_master_arb;
  localparam int DW = 32, AW = 32, T = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1, paddr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, pwdata, prdata;
  logic          done0, done1, err0, err1, penable, pwrite, pready, pslverr;
  logic [1:0]    psel;

  always #5 clk = ~clk;

  apb_master_arb #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave: ready after plan_w wait cycles of ACCESS; noise on ignored inputs otherwise.
  int          plan_w = 0, acc = 0;
  logic        plan_se = 1'b0;
  logic [31:0] plan_rd = 32'h0;

  always @(negedge clk) begin
    if (psel != 2'b00 && penable) begin
      acc = acc + 1;
      if (acc > plan_w) begin
        pready = 1'b1; prdata = plan_rd; pslverr = plan_se;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end
    end else begin
      acc = 0;
      pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
    end
  end

  logic tb_last = 1'b1;

  function automatic bit pick(input bit r0, input bit r1);
    return (r0 && r1) ? !tb_last : r1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_psel"}, psel, 0);    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0); chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0); chk({tag, "_done0"}, done0, 0);
    chk({tag, "_done1"}, done1, 0);   chk({tag, "_err0"}, err0, 0);
    chk({tag, "_err1"}, err1, 0);     chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
  endtask

  task automatic start(input bit id, input logic [31:0] a, input bit wr, input logic [31:0] wd);
    if (id) begin req1 = 1'b1; addr1 = a; wr1 = wr; wdata1 = wd; end
    else    begin req0 = 1'b1; addr0 = a; wr0 = wr; wdata0 = wd; end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("gap_done0", done0, 0); chk("gap_done1", done1, 0); chk("gap_psel", psel, 0);
    end
  endtask

  // Called at the negedge of the IDLE cycle in which requester id gets granted.
  task automatic xfer(input bit id, input int w, input bit se, input logic [31:0] rd, input bit drop);
    logic [31:0] a, wd, erd;
    bit          wr, dec, e;
    logic [1:0]  tgt;
    int          lat;
    a  = id ? addr1 : addr0;
    wr = id ? wr1 : wr0;
    wd = id ? wdata1 : wdata0;
    case (a[15:12])
      4'h1:    tgt = 2'b01;
      4'h2:    tgt = 2'b10;
      default: tgt = 2'b00;
    endcase
    dec = (tgt == 2'b00);
    lat = dec ? 1 : 3 + ((w < T - 1) ? w : T - 1);
    e   = dec || (w >= T) || se;
    erd = (!e && !wr) ? rd : 32'h0;
    plan_w = w; plan_se = se; plan_rd = rd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("done", id ? done1 : done0, 64'(k == lat));
      chk("done_other", id ? done0 : done1, 0);
      if (k == lat) begin
        chk("err", id ? err1 : err0, 64'(e));
        chk("rdata", id ? rdata1 : rdata0, erd);
        chk("err_other", id ? err0 : err1, 0);
        chk("psel_resp", psel, 0);
        chk("penable_resp", penable, 0);
      end else if (k == 1) begin
        chk("psel_setup", psel, tgt);
        chk("penable_setup", penable, 0);
        chk("paddr_setup", paddr, a);
        chk("pwrite_setup", pwrite, 64'(wr));
        if (wr) chk("pwdata_setup", pwdata, wd);
      end else begin
        chk("psel_access", psel, tgt);
        chk("penable_access", penable, 1);
        chk("paddr_access", paddr, a);
      end
    end
    tb_last = id;
    if (drop) begin
      if (id) req1 = 1'b0; else req0 = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    a = $urandom;
    r = $urandom_range(0, 9);
    a[15:12] = (r < 4) ? 4'h1 : (r < 8) ? 4'h2 : 4'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    bit id, other, r0, r1;
    int m;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pready = 0; pslverr = 0; prdata = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");

    // Both requesting at reset exit and held: grants alternate 0,1,0,1.
    start(0, 32'h0000_2000, 1, 32'hA5A5_A5A5);
    start(1, 32'h0000_1004, 0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id = pick(req0, req1);
      chk("contend_order", 64'(id), 64'(i % 2));
      xfer(id, 0, 0, $urandom, 0);
      if (i == 3) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      chk("contend_idle_done0", done0, 0); chk("contend_idle_done1", done1, 0);
    end
    gap(2);

    start(0, 32'h0000_2000, 1, 32'hA5A5_A5A5); xfer(0, 0, 0, 32'h0, 1);         gap(1);
    start(1, 32'h0000_1004, 0, 32'h0);         xfer(1, 4, 0, 32'h1234_5678, 1); gap(1);
    start(0, 32'h0000_1008, 0, 32'h0);         xfer(0, 100, 0, 32'hDEAD_BEEF, 1); gap(1);
    start(0, 32'h0000_1008, 0, 32'h0);         xfer(0, T - 1, 0, 32'hCAFE_F00D, 1); gap(1);
    start(0, 32'h0000_3000, 1, 32'h1111_2222); xfer(0, 0, 0, 32'h0, 1);         gap(1);
    start(0, 32'h0000_2010, 1, 32'h3333_4444); xfer(0, 0, 1, 32'h0, 1);         gap(1);

    // Reset while in ACCESS: bus dropped, no done, then a fresh transfer works.
    start(1, 32'h0000_2004, 0, 32'h0);
    plan_w = 50;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_penable", penable, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("rst_mid");
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tb_last = 1'b1;
    start(1, 32'h0000_1010, 0, 32'h0);
    xfer(1, 2, 0, 32'h0BAD_CAFE, 1);
    gap(1);

    for (int it = 0; it < 40; it++) begin
      m  = $urandom_range(1, 3);
      r0 = m[0]; r1 = m[1];
      if (r0) start(0, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
      if (r1) start(1, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
      id = pick(r0, r1);
      xfer(id, $urandom_range(0, T + 2), ($urandom_range(0, 3) == 0), $urandom, 1);
      if (r0 && r1) begin
        other = !id;
        @(negedge clk);
        chk("rr_idle_done0", done0, 0); chk("rr_idle_done1", done1, 0);
        xfer(other, $urandom_range(0, T + 2), ($urandom_range(0, 3) == 0), $urandom, 1);
      end
      gap($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-port APB master and arbiter that shares the peripheral APB bus (UART and GPIO slaves) between two requesters, e.g. the CPU port and a DMA/test port. It accepts simple request/done transactions from each requester, arbitrates round-robin, decodes the target slave from the address, and sequences the APB SETUP/ACCESS phases. A per-transfer timeout guarantees forward progress when a slave never asserts `pready`.

## Interface
- `DATA_W`, 32: width of the `wdata`, `rdata`, `pwdata` and `prdata` buses.
- `ADDR_W`, 32: width of the `addr` and `paddr` buses; must be ≥ 16.
- `TIMEOUT`, 255: maximum number of ACCESS cycles waited for `pready`; legal range 1..255.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0`, `req1`  in  1  transfer request; held high until the matching `done` is seen.
- `addr0`, `addr1`  in  ADDR_W  request address; must be stable while `req` is high.
- `wr0`, `wr1`  in  1  direction: 1 = write, 0 = read; stable while `req` is high.
- `wdata0`, `wdata1`  in  DATA_W  write data; stable while `req` is high.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `err0`, `err1`  out  1  valid with `done`: decode error, `pslverr`, or timeout.
- `rdata0`, `rdata1`  out  DATA_W  read data, valid with `done`; 0 for writes and errors.
- `psel`  out  2  slave select: 2'b01 = GPIO, 2'b10 = UART, 2'b00 = idle.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `paddr`  out  ADDR_W  APB address.
- `pwdata`  out  DATA_W  APB write data.
- `prdata`  in  DATA_W  APB read data.
- `pready`  in  1  slave ready.
- `pslverr`  in  1  slave error; sampled only together with `pready`.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - If no `req` is high, stay in IDLE.
  - If exactly one `req` is high, grant that requester.
  - If both are high, grant the requester that was not served last.
  - The last-served pointer resets to 1, so `req0` wins the first tie.
- **Address decode** of the granted `addr[15:12]`:
  - 4'h1 selects GPIO.
  - 4'h2 selects UART.
  - Any other value is a decode error: go directly IDLE→RESP with `err`=1; no bus activity occurs.
- **Latch on grant:** the arbiter captures `addr`, `wr`, `wdata`, the target and the requester id into internal registers. All APB outputs are driven from these registers, not from the requester inputs.
- **SETUP:** `psel` = target, `penable`=0, `paddr`/`pwrite`/`pwdata` driven. Lasts exactly one cycle, then ACCESS.
- **ACCESS:** `psel` held, `penable`=1. An 8-bit wait counter starts at 0 and increments every ACCESS cycle.
  - `pready`=1: capture `prdata` (reads only) and `pslverr`, then go to RESP.
  - `pready`=0 and counter = TIMEOUT−1: abort with `err`=1 and `rdata`=0, then go to RESP.
- **RESP:**
  - `psel`=0, `penable`=0.
  - `done`/`err`/`rdata` are driven to the granted requester only.
  - The last-served pointer is updated.
  - Next state is IDLE.
- **Requester rule:** drop `req` (or present a new transaction) in the cycle after `done`. `req` is not sampled in SETUP, ACCESS or RESP.
- **Bus idle values:** `paddr`, `pwdata` and `pwrite` return to 0 whenever `psel` = 0.

## Timing
- **Reset values:** every output is 0; state = IDLE; wait counter = 0; last-served = 1.
- **Reset mid-transfer:** on the first clock edge with `rst_n`=0, the bus is dropped (`psel`=0, `penable`=0), no `done` is issued, and the FSM returns to IDLE.
- **Zero-wait transfer:** `req` high in IDLE at cycle c → SETUP at c+1 → ACCESS at c+2 with `pready`=1 → `done` at c+3. Minimum latency is 3 cycles.
- **Wait states:** each cycle of `pready`=0 adds one cycle; `penable` stays high throughout.
- **Timeout:** exactly TIMEOUT ACCESS cycles, then RESP. With TIMEOUT=255, `done` arrives at c+2+255.
- **Decode error:** `done`+`err` at c+1.
- **Back-to-back:** the next grant is evaluated in the IDLE cycle after RESP. Minimum spacing between transfers is 4 cycles.
- **Simultaneous events:**
  - `pready` on the last timeout cycle counts as a normal completion, not a timeout.
  - `pslverr` with `pready`=0 is ignored.
- **Outputs:** all are registered; no combinational path from `req` or `pready` to any output.

## Test plan
- **Single write:** `req0`, `addr0`=0x2000, `wr0`=1, `wdata0`=0xA5A5A5A5, `pready` tied 1 → SETUP with `psel`=2'b10 and `pwdata`=0xA5A5A5A5; `penable` next cycle; `done0`=1, `err0`=0 exactly 3 cycles after `req`.
- **Wait-state read:** `req1`, `addr1`=0x1004, `wr1`=0; `pready` low for 4 ACCESS cycles, then high with `prdata`=0x12345678 → `psel`=2'b01; `done1` at c+7 with `rdata1`=0x12345678.
- **Contention:** `req0` and `req1` both high at reset exit → `req0` served first, then `req1`. With both held continuously, grants alternate 0,1,0,1 and `done` pulses are 4 cycles apart.
- **Timeout and decode error:** TIMEOUT=8, `pready` stuck 0 → `done0` with `err0`=1 and `rdata0`=0 after 8 ACCESS cycles, `psel` cleared. Separately, `addr0`=0x3000 → `done0`+`err0` at c+1 with `psel` never asserted.
- **Slave error:** `pready`=1 with `pslverr`=1 on a UART write → `err0`=1 in the `done` cycle.
- **Reset mid-access:** `rst_n` low during ACCESS → next edge shows all outputs 0, no `done`. After release, a fresh `req1` completes normally.
